mult8_seq: RTL
==============

# mult8_seq

Sequential shift-add unsigned multiplier controller that sequences the team's 8-bit D-flip-flop register datapath. It captures two WIDTH-bit operands on a start request and iterates one partial-product step per clock. After WIDTH steps it presents a 2*WIDTH-bit product and signals completion with a start/busy/done handshake. It sits between a requesting arithmetic unit and the shared multiplicand, multiplier and accumulator registers.

## Interface
- WIDTH, 8, operand width in bits (legal range 2..16); product is 2*WIDTH bits
- clock  input  1  rising-edge clock for all state
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  multiplicand; captured at the accepting edge
- b  input  WIDTH  multiplier; captured at the accepting edge
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle completion pulse
- product  output  2*WIDTH  registered result; holds until overwritten

## Operation
- Internal registers:
  - mcand (WIDTH bits)
  - mplier (WIDTH bits)
  - acc_hi (WIDTH+1 bits, includes carry)
  - count (ceil(log2(WIDTH+1)) bits)
  - state
- State IDLE:
  - busy=0, done=0.
  - If start=1 at an edge: mcand<=a, mplier<=b, acc_hi<=0, count<=0, go to RUN.
- State RUN, one step per edge:
  - sum = acc_hi[WIDTH-1:0] + (mplier[0] ? mcand : 0), computed WIDTH+1 bits wide with no overflow loss.
  - {acc_hi, mplier} <= {1'b0, sum, mplier} >> 1. The low product bits shift into mplier as its bits are consumed.
  - count <= count+1.
  - On the step where count==WIDTH-1: product <= {sum, mplier} >> 1 (the final value), then go to DONE.
- State DONE:
  - done=1, busy=1, for exactly one cycle.
  - Next edge goes to IDLE unconditionally.
- start is ignored in RUN and DONE; it is not queued.
- Operands a and b may change freely after the accepting edge.
- product changes only at the final RUN edge and at reset. It holds across IDLE and across later accepted starts until their final step.
- Arithmetic is unsigned. The maximum result (2^WIDTH-1)^2 fits in 2*WIDTH bits with no truncation.
- Unused state encodings recover to IDLE on the next edge.

## Timing
- Reset (reset_n=0, asynchronous, independent of clock):
  - state=IDLE, busy=0, done=0, product=0.
  - All internal registers are 0.
- Reset deassertion is synchronous-safe: the first edge with reset_n=1 may accept start.
- Latency: start accepted at edge E0, RUN steps at edges E1..EWIDTH.
  - product valid and done=1 after edge EWIDTH, i.e. WIDTH cycles after acceptance.
  - done falls, busy falls, and IDLE is re-entered at edge EWIDTH+1.
- Throughput: the earliest next acceptance is edge EWIDTH+2. One operation takes WIDTH+2 cycles.
- busy rises after E0 and falls after EWIDTH+1.
- Reset mid-RUN or in DONE aborts the operation immediately.
  - done is never emitted for the aborted operation.
  - product returns to 0.
- start held high continuously: operations run back-to-back with one IDLE cycle between them; each is accepted at its IDLE edge.

## Test plan
- Reset, then start with a=0x0D, b=0x0B. Required: busy high for cycles 1..9, done pulses exactly once at cycle 8 after acceptance, product=0x008F.
- a=0xFF, b=0xFF. Required: product=0xFE01 with no overflow. Then a=0x00, b=0xA5: product=0x0000 and done still pulses after 8 cycles.
- Accept a=0x03, b=0x05, then pulse start with a=0x77, b=0x77 at cycles 3 and 9 (in RUN and in DONE). Required: both ignored, product=0x000F, exactly one done pulse.
- Assert reset_n=0 mid-operation at cycle 4 after accepting a=0x12, b=0x34. Required: busy=0, done=0, product=0 immediately with no clock edge, and no done pulse follows. A fresh start with a=0x12, b=0x34 then yields 0x03A8.
- Hold start=1 with changing operands (0x02x0x03, then 0x10x0x10). Required: products 0x0006 then 0x0100, done pulses 10 cycles apart, product holds 0x0006 until the second final edge.
- WIDTH=4 build with a=0xF, b=0xF. Required: product=0xE1 (8 bits), done 4 cycles after acceptance.

Source files
------------

// File: rtl/mult8_seq.sv
`default_nettype none
// ============================================================================
// Module   : mult8_seq
// Brief    : Sequential shift-add unsigned multiplier, one partial product/clk.
// Revision : 1.0 - initial release
// ============================================================================
module mult8_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int            c_cw   = $clog2(WIDTH + 1);
  localparam logic [c_cw-1:0] c_last = c_cw'(WIDTH - 1);
  localparam logic [c_cw-1:0] c_one  = c_cw'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              w_accept;
  logic              w_last;
  logic [WIDTH-1:0]  r_mcand;
  logic [WIDTH-1:0]  r_mplier;
  logic [WIDTH:0]    r_acc_hi;
  logic [c_cw-1:0]   r_count;
  logic [WIDTH:0]    w_sum;

  // acc_hi's top bit is always zero entering a step, so the full-width add
  // cannot overflow WIDTH+1 bits.
  assign w_sum  = r_acc_hi + (r_mplier[0] ? {1'b0, r_mcand} : '0);
  assign w_last = (r_count == c_last);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next   = S_IDLE;
    w_accept = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next   = S_RUN;
          w_accept = 1'b1;
        end
      end
      S_RUN: begin
        busy   = 1'b1;
        w_next = w_last ? S_DONE : S_RUN;
      end
      S_DONE: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc_hi <= '0;
      r_count  <= '0;
      product  <= '0;
    end else if (w_accept) begin
      r_mcand  <= a;
      r_mplier <= b;
      r_acc_hi <= '0;
      r_count  <= '0;
    end else if (r_state == S_RUN) begin
      // Low product bits migrate into mplier as multiplier bits are consumed.
      r_acc_hi <= {1'b0, w_sum[WIDTH:1]};
      r_mplier <= {w_sum[0], r_mplier[WIDTH-1:1]};
      r_count  <= r_count + c_one;
      if (w_last) product <= {w_sum, r_mplier[WIDTH-1:1]};
    end
  end

endmodule
`default_nettype wire
